// File: rtl/mdu_def.sv
// Shared op-code constants for the multiply/divide unit; the control-unit decode
// imports these to generate mdop/start.
package mdu_def;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result datapath: (a, b, op) -> {hi, lo}. Kept separate so it can be
// swapped for an iterative divider without touching the counter/commit logic.
module mdu_calc
    import mdu_def::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  mdop,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic        sgn;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        sgn   = is_signed_op(mdop);
        a_ext = {{32{sgn & a[31]}}, a};
        b_ext = {{32{sgn & b[31]}}, b};
        prod  = a_ext * b_ext;

        // Magnitude divide avoids the signed-overflow corner (0x80000000 / -1).
        a_mag = (sgn && a[31]) ? -a : a;
        b_mag = (sgn && b[31]) ? -b : b;
        dvs   = (b_mag == 32'd0) ? 32'd1 : b_mag;
        quo   = a_mag / dvs;
        rem   = a_mag % dvs;
        if (sgn && (a[31] ^ b[31])) quo = -quo;
        if (sgn && a[31])           rem = -rem;

        if (is_div(mdop)) begin
            hi = rem;
            lo = quo;
        end else begin
            hi = prod[63:32];
            lo = prod[31:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: accepts an op when idle, holds the
// result for a fixed number of busy cycles, then commits it to HI/LO.
module mult_div_unit
    import mdu_def::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  mdop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic [31:0]   hi_r;
    logic [31:0]   lo_r;
    logic [31:0]   hi_p;
    logic [31:0]   lo_p;
    logic [31:0]   calc_hi;
    logic [31:0]   calc_lo;

    mdu_calc u_calc (
        .a    (a),
        .b    (b),
        .mdop (mdop),
        .hi   (calc_hi),
        .lo   (calc_lo)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            hi_r <= '0;
            lo_r <= '0;
            hi_p <= '0;
            lo_p <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                hi_r <= hi_p;
                lo_r <= lo_p;
            end
        end else if (start) begin
            case (mdop)
                MD_MULT, MD_MULTU: begin
                    hi_p <= calc_hi;
                    lo_p <= calc_lo;
                    cnt  <= CW'(MULT_CYCLES);
                end
                MD_DIV, MD_DIVU: begin
                    // Divide by zero still takes the full latency but leaves HI/LO intact.
                    hi_p <= (b == 32'd0) ? hi_r : calc_hi;
                    lo_p <= (b == 32'd0) ? lo_r : calc_lo;
                    cnt  <= CW'(DIV_CYCLES);
                end
                MD_MTHI: hi_r <= a;
                MD_MTLO: lo_r <= a;
                default: ;
            endcase
        end
    end

    assign busy = (cnt != '0);
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
